// File: rtl/risc16_pkg.sv
// risc16_pkg: shared opcodes, state codes and datapath select encodings for the RiSC-16 sequencer
package risc16_pkg;
    localparam int IMM_W = 7;
    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_ADDI = 3'b001;
    localparam logic [2:0] OP_NAND = 3'b010;
    localparam logic [2:0] OP_LUI  = 3'b011;
    localparam logic [2:0] OP_SW   = 3'b100;
    localparam logic [2:0] OP_LW   = 3'b101;
    localparam logic [2:0] OP_BEQ  = 3'b110;
    localparam logic [2:0] OP_JALR = 3'b111;
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_FAULT  = 3'd6;
    localparam logic [2:0] S_HALT   = 3'd7;
    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_NAND = 2'b01;
    localparam logic [1:0] ALU_PASS = 2'b10;
    localparam logic [1:0] ALU_SUB  = 2'b11;
    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC  = 2'b10;
    localparam logic [1:0] PC_INC = 2'b00;
    localparam logic [1:0] PC_IMM = 2'b01;
    localparam logic [1:0] PC_RB  = 2'b10;
endpackage

// File: rtl/risc16_mem_timer.sv
// risc16_mem_timer: counts unacknowledged memory-request cycles and flags the cycle the limit is hit
module risc16_mem_timer #(
    parameter int LIMIT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic req,
    input  logic ack,
    input  logic clear,
    output logic expired
);
    logic [7:0] cnt;

    // The limit-th waiting cycle expires unless ack arrives in that same cycle
    assign expired = req && !ack && (cnt == 8'(LIMIT - 1));

    // Count waiting cycles; any ack or state change restarts the count
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else
            cnt <= (clear || ack) ? '0 : req ? cnt + 8'd1 : cnt;
    end
endmodule

// File: rtl/risc16_mc_ctrl.sv
// risc16_mc_ctrl: multi-cycle RiSC-16 control sequencer; optional HALT decode via RISC16_HALT_EN
module risc16_mc_ctrl
    import risc16_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run_en,
    input  logic [15:0]      instr,
    input  logic             alu_zero,
    input  logic             mem_ack,
    output logic             mem_req,
    output logic             mem_we,
    output logic             mem_addr_sel,
    output logic             ir_load,
    output logic [1:0]       alu_op,
    output logic             alu_src_imm,
    output logic             reg_we,
    output logic [1:0]       wb_sel,
    output logic             pc_we,
    output logic [1:0]       pc_sel,
    output logic             busy,
    output logic             bus_err,
`ifdef RISC16_HALT_EN
    output logic             halted,
`endif
    output logic [CNT_W-1:0] instret
);
    logic [2:0] state, next, op;
    logic       retire, expired, is_halt;
    logic [2:0] after_retire;

    assign op           = instr[15:13];
    assign after_retire = run_en ? S_FETCH : S_IDLE;
    assign busy         = state != S_IDLE;
    assign bus_err      = state == S_FAULT;
`ifdef RISC16_HALT_EN
    assign is_halt = (op == OP_JALR) && (instr[IMM_W-1:0] != '0);
    assign halted  = state == S_HALT;
`else
    assign is_halt = 1'b0;
`endif

    risc16_mem_timer #(.LIMIT(MEM_TIMEOUT)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .req    (mem_req),
        .ack    (mem_ack),
        .clear  (next != state),
        .expired(expired)
    );

    // Decode datapath controls and the next state from the current state and instruction
    always_comb begin
        next         = state;
        retire       = 1'b0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_load      = 1'b0;
        alu_op       = ALU_ADD;
        alu_src_imm  = 1'b0;
        reg_we       = 1'b0;
        wb_sel       = WB_ALU;
        pc_we        = 1'b0;
        pc_sel       = PC_INC;
        case (state)
            S_IDLE: next = run_en ? S_FETCH : S_IDLE;
            S_FETCH: begin
                mem_req = 1'b1;
                ir_load = mem_ack;
                next    = mem_ack ? S_DECODE : expired ? S_FAULT : S_FETCH;
            end
            S_DECODE: next = S_EXEC;
            S_EXEC: begin
                case (op)
                    OP_ADD:  next = S_WB;
                    OP_ADDI: begin
                        alu_src_imm = 1'b1;
                        next        = S_WB;
                    end
                    OP_NAND: begin
                        alu_op = ALU_NAND;
                        next   = S_WB;
                    end
                    OP_LUI: begin
                        alu_op = ALU_PASS;
                        next   = S_WB;
                    end
                    OP_SW, OP_LW: begin
                        alu_src_imm = 1'b1;
                        next        = S_MEM;
                    end
                    OP_BEQ: begin
                        alu_op = ALU_SUB;
                        pc_we  = 1'b1;
                        pc_sel = alu_zero ? PC_IMM : PC_INC;
                        retire = 1'b1;
                        next   = after_retire;
                    end
                    default: begin
                        reg_we = !is_halt;
                        wb_sel = is_halt ? WB_ALU : WB_PC;
                        pc_we  = !is_halt;
                        pc_sel = is_halt ? PC_INC : PC_RB;
                        retire = 1'b1;
                        next   = is_halt ? S_HALT : after_retire;
                    end
                endcase
            end
            S_MEM: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = op == OP_SW;
                pc_we        = mem_ack && (op == OP_SW);
                retire       = mem_ack && (op == OP_SW);
                next         = !mem_ack ? (expired ? S_FAULT : S_MEM) : (op == OP_SW) ? after_retire : S_WB;
            end
            S_WB: begin
                reg_we = 1'b1;
                wb_sel = (op == OP_LW) ? WB_MEM : WB_ALU;
                pc_we  = 1'b1;
                retire = 1'b1;
                next   = after_retire;
            end
            default: next = state;
        endcase
    end

    // Advance the sequencer and count every retired instruction
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            instret <= '0;
        end else begin
            state <= next;
            if (retire)
                instret <= instret + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_risc16_mc_ctrl.sv
// tb_risc16_mc_ctrl: randomized instruction streams checked against a per-instruction expected-trace model
module tb_risc16_mc_ctrl;
    import risc16_pkg::*;

    logic        clk, rst, run_en, alu_zero, mem_ack;
    logic [15:0] instr;
    logic        mem_req, mem_we, mem_addr_sel, ir_load, alu_src_imm, reg_we, pc_we, busy, bus_err;
    logic [1:0]  alu_op, wb_sel, pc_sel;
    logic [15:0] instret;
`ifdef RISC16_HALT_EN
    logic        halted;
`endif

    risc16_mc_ctrl #(.MEM_TIMEOUT(15), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .run_en(run_en), .instr(instr), .alu_zero(alu_zero), .mem_ack(mem_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel), .ir_load(ir_load),
        .alu_op(alu_op), .alu_src_imm(alu_src_imm), .reg_we(reg_we), .wb_sel(wb_sel),
        .pc_we(pc_we), .pc_sel(pc_sel), .busy(busy), .bus_err(bus_err),
`ifdef RISC16_HALT_EN
        .halted(halted),
`endif
        .instret(instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          total = 0, passed = 0;
    logic        chk_en = 1'b0;
    logic [14:0] exp_v;
    logic [15:0] exp_ret, ret_cnt;
    logic [15:0] cur_instr;
    logic        cur_z;
    logic [14:0] act;

    assign act = {mem_req, mem_we, mem_addr_sel, ir_load, alu_op, alu_src_imm, reg_we, wb_sel, pc_we, pc_sel, busy, bus_err};

    function automatic logic [14:0] mk(input logic req, we, as, irl, input logic [1:0] aop, input logic imm, rwe,
                                       input logic [1:0] wbs, input logic pwe, input logic [1:0] psel, input logic bsy, berr);
        return {req, we, as, irl, aop, imm, rwe, wbs, pwe, psel, bsy, berr};
    endfunction

    // Compare every enabled cycle's outputs against the expected trace, away from the clock edge
    always @(negedge clk) begin
        if (chk_en) begin
            total++;
            if (act !== exp_v || instret !== exp_ret)
                $display("FAIL cycle t=%0t outputs=%h required=%h instret=%0d required=%0d", $time, act, exp_v, instret, exp_ret);
            else
                passed++;
        end
    end

    task automatic chk(input string name, input logic [15:0] a, input logic [15:0] e);
        total++;
        if (a !== e) $display("FAIL %s actual=%0d required=%0d", name, a, e);
        else passed++;
    endtask

    task automatic cyc(input logic [14:0] ev, input logic ack, input logic ret, input logic run);
        mem_ack  = ack;
        run_en   = run;
        instr    = cur_instr;
        alu_zero = cur_z;
        exp_v    = ev;
        exp_ret  = ret_cnt;
        chk_en   = 1'b1;
        @(posedge clk);
        #1;
        if (ret) ret_cnt++;
    endtask

    function automatic logic nr(input logic last);
        return last ? 1'b0 : 1'($urandom_range(0, 1));
    endfunction

    task automatic do_reset();
        chk_en = 1'b0;
        rst    = 1'b1;
        #1;
        chk("rst_mem_req", {15'd0, mem_req}, 16'd0);
        chk("rst_instret", instret, 16'd0);
        chk("rst_busy_err", {14'd0, busy, bus_err}, 16'd0);
        @(posedge clk);
        #1;
        rst     = 1'b0;
        run_en  = 1'b0;
        mem_ack = 1'b0;
        ret_cnt = '0;
    endtask

    task automatic fault_seq();
        for (int k = 0; k < 3; k++)
            cyc(mk(0, 0, 0, 0, 2'd0, 0, 0, 2'd0, 0, 2'd0, 1, 1), 1'($urandom_range(0, 1)), 0, 1'($urandom_range(0, 1)));
        #1;
        chk("fault_bus_err", {15'd0, bus_err}, 16'd1);
        chk("fault_mem_req", {15'd0, mem_req}, 16'd0);
        do_reset();
    endtask

    // Expected trace of one instruction: fetch waits, decode, execute, optional memory and writeback
    task automatic run_instr(input logic [2:0] op, input int fw, input int mw, input logic z, input logic last, input logic from_idle);
        logic [15:0] i;
        logic        rr, sw, lw, imm;
        logic [1:0]  aop;
        i = 16'($urandom);
        i[15:13] = op;
`ifdef RISC16_HALT_EN
        if (op == OP_JALR) i[6:0] = '0;
`endif
        cur_instr = i;
        cur_z     = z;
        rr  = !last;
        sw  = op == OP_SW;
        lw  = op == OP_LW;
        if (from_idle) cyc(15'd0, 0, 0, 1);
        for (int k = 0; k < fw && k < 15; k++) cyc(mk(1, 0, 0, 0, 2'd0, 0, 0, 2'd0, 0, 2'd0, 1, 0), 0, 0, nr(last));
        if (fw >= 15) begin
            fault_seq();
            return;
        end
        cyc(mk(1, 0, 0, 1, 2'd0, 0, 0, 2'd0, 0, 2'd0, 1, 0), 1, 0, nr(last));
        cyc(mk(0, 0, 0, 0, 2'd0, 0, 0, 2'd0, 0, 2'd0, 1, 0), 0, 0, nr(last));
        if (op == OP_BEQ) begin
            cyc(mk(0, 0, 0, 0, 2'd3, 0, 0, 2'd0, 1, z ? 2'd1 : 2'd0, 1, 0), 0, 1, rr);
            return;
        end
        if (op == OP_JALR) begin
            cyc(mk(0, 0, 0, 0, 2'd0, 0, 1, 2'd2, 1, 2'd2, 1, 0), 0, 1, rr);
            return;
        end
        aop = (op == OP_NAND) ? 2'd1 : (op == OP_LUI) ? 2'd2 : 2'd0;
        imm = (op == OP_ADDI) || sw || lw;
        cyc(mk(0, 0, 0, 0, aop, imm, 0, 2'd0, 0, 2'd0, 1, 0), 0, 0, nr(last));
        if (sw || lw) begin
            for (int k = 0; k < mw && k < 15; k++) cyc(mk(1, sw, 1, 0, 2'd0, 0, 0, 2'd0, 0, 2'd0, 1, 0), 0, 0, nr(last));
            if (mw >= 15) begin
                fault_seq();
                return;
            end
            if (sw) begin
                cyc(mk(1, 1, 1, 0, 2'd0, 0, 0, 2'd0, 1, 2'd0, 1, 0), 1, 1, rr);
                return;
            end
            cyc(mk(1, 0, 1, 0, 2'd0, 0, 0, 2'd0, 0, 2'd0, 1, 0), 1, 0, nr(last));
        end
        cyc(mk(0, 0, 0, 0, 2'd0, 0, 1, {1'b0, lw}, 1, 2'd0, 1, 0), 0, 1, rr);
    endtask

    initial begin
        logic was_last;
        logic last;
        int   fw, mw;
        rst = 1'b1; run_en = 1'b0; mem_ack = 1'b0; instr = '0; alu_zero = 1'b0;
        ret_cnt = '0; cur_instr = '0; cur_z = 1'b0; exp_v = '0; exp_ret = '0;
        do_reset();
        cyc(15'd0, 0, 0, 0);
        run_instr(OP_ADDI, 0, 0, 0, 0, 1);
        #1;
        chk("addi_cycle5_fetch", {15'd0, mem_req}, 16'd1);
        chk("addi_instret", instret, 16'd1);
        run_instr(OP_LW, 2, 2, 0, 0, 0);
        run_instr(OP_BEQ, 0, 0, 1, 0, 0);
        run_instr(OP_BEQ, 1, 0, 0, 0, 0);
        run_instr(OP_LW, 14, 14, 0, 0, 0);
        run_instr(OP_SW, 1, 2, 0, 1, 0);
        #1;
        chk("sw_then_idle_busy", {15'd0, busy}, 16'd0);
        chk("six_retired", instret, 16'd6);
        run_instr(OP_ADD, 0, 0, 0, 0, 1);
        run_instr(OP_LW, 15, 0, 0, 0, 0);
        run_instr(OP_ADD, 0, 0, 0, 0, 1);
        run_instr(OP_SW, 0, 15, 0, 0, 0);
        run_instr(OP_NAND, 0, 0, 0, 0, 1);
        cur_instr = {OP_SW, 13'h0005};
        cyc(mk(1, 0, 0, 1, 2'd0, 0, 0, 2'd0, 0, 2'd0, 1, 0), 1, 0, 1);
        cyc(mk(0, 0, 0, 0, 2'd0, 0, 0, 2'd0, 0, 2'd0, 1, 0), 0, 0, 1);
        cyc(mk(0, 0, 0, 0, 2'd0, 1, 0, 2'd0, 0, 2'd0, 1, 0), 0, 0, 1);
        cyc(mk(1, 1, 1, 0, 2'd0, 0, 0, 2'd0, 0, 2'd0, 1, 0), 0, 0, 1);
        chk_en = 1'b0;
        #1;
        chk("mem_req_before_rst", {15'd0, mem_req}, 16'd1);
        do_reset();
        was_last = 1'b1;
        for (int n = 0; n < 150; n++) begin
            fw   = ($urandom_range(0, 19) == 0) ? 14 : int'($urandom_range(0, 3));
            mw   = ($urandom_range(0, 19) == 0) ? 14 : int'($urandom_range(0, 3));
            last = $urandom_range(0, 7) == 0;
            run_instr(3'($urandom_range(0, 7)), fw, mw, 1'($urandom_range(0, 1)), last, was_last);
            was_last = last;
        end
`ifdef RISC16_HALT_EN
        if (was_last) cyc(15'd0, 0, 0, 1);
        cur_instr = {OP_JALR, 6'd0, 7'd1};
        cyc(mk(1, 0, 0, 1, 2'd0, 0, 0, 2'd0, 0, 2'd0, 1, 0), 1, 0, 1);
        cyc(mk(0, 0, 0, 0, 2'd0, 0, 0, 2'd0, 0, 2'd0, 1, 0), 0, 0, 1);
        cyc(mk(0, 0, 0, 0, 2'd0, 0, 0, 2'd0, 0, 2'd0, 1, 0), 0, 1, 1);
        cyc(mk(0, 0, 0, 0, 2'd0, 0, 0, 2'd0, 0, 2'd0, 1, 0), 1, 0, 1);
        cyc(mk(0, 0, 0, 0, 2'd0, 0, 0, 2'd0, 0, 2'd0, 1, 0), 0, 0, 0);
        #1;
        chk("halted", {15'd0, halted}, 16'd1);
`endif
        chk_en = 1'b0;
        #1;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
